// File: rtl/branch_pkg.sv
// -----------------------------------------------------------------------------
// branch_pkg
// Shared definitions for the branch resolution unit: RISC-V style branch
// funct3 encodings, the BHT counter type and its four named states.
// -----------------------------------------------------------------------------
package branch_pkg;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  typedef logic [1:0] bht_cnt_t;

  localparam bht_cnt_t CNT_SNT = 2'd0;  // strongly not-taken
  localparam bht_cnt_t CNT_WNT = 2'd1;  // weakly not-taken
  localparam bht_cnt_t CNT_WT  = 2'd2;  // weakly taken
  localparam bht_cnt_t CNT_ST  = 2'd3;  // strongly taken

endpackage

// File: rtl/branch_cond.sv
// -----------------------------------------------------------------------------
// branch_cond
// Purely combinational branch condition evaluation.
// Ports:
//   funct3  in   branch condition encoding
//   rs1     in   first operand
//   rs2     in   second operand
//   cond    out  condition true for the decoded comparison
//   legal   out  funct3 is a defined branch encoding (010/011 are not)
// -----------------------------------------------------------------------------
module branch_cond
  import branch_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  output logic            cond,
  output logic            legal
);

  logic w_eq;
  logic w_lt_s;
  logic w_lt_u;

  assign w_eq   = (rs1 == rs2);
  assign w_lt_s = ($signed(rs1) < $signed(rs2));
  assign w_lt_u = (rs1 < rs2);

  always_comb begin
    cond  = 1'b0;
    legal = 1'b1;
    unique case (funct3)
      F3_BEQ:  cond = w_eq;
      F3_BNE:  cond = ~w_eq;
      F3_BLT:  cond = w_lt_s;
      F3_BGE:  cond = ~w_lt_s;
      F3_BLTU: cond = w_lt_u;
      F3_BGEU: cond = ~w_lt_u;
      default: legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_unit_bht.sv
// -----------------------------------------------------------------------------
// branch_unit_bht
// Branch resolution unit with a 2-bit saturating-counter branch history table.
// Fetch side gets a registered prediction one cycle after a lookup; execute
// side resolves conditional branches, trains the table and raises a one-cycle
// registered mispredict with the corrected next PC.
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   pred_valid, pred_pc       fetch lookup request
//   pred_taken                registered prediction (counter MSB), held when idle
//   pred_taken_valid          pred_valid delayed one cycle
//   res_valid, res_branch     execute-stage instruction is a valid branch
//   res_funct3, res_rs1/rs2   branch condition and operands
//   res_pc, res_target        branch PC and computed target
//   res_predicted             prediction that travelled with this branch
//   taken                     combinational resolved outcome
//   mispredict, redirect_pc   registered redirect pulse and correct next PC
//   br_count, mis_count       free-running resolved/mispredict counters
// -----------------------------------------------------------------------------
module branch_unit_bht
  import branch_pkg::*;
#(
  parameter int       XLEN     = 32,
  parameter int       ENTRIES  = 64,
  parameter bht_cnt_t CNT_INIT = 2'b01
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            pred_valid,
  input  logic [XLEN-1:0] pred_pc,
  output logic            pred_taken,
  output logic            pred_taken_valid,
  input  logic            res_valid,
  input  logic            res_branch,
  input  logic [2:0]      res_funct3,
  input  logic [XLEN-1:0] res_rs1,
  input  logic [XLEN-1:0] res_rs2,
  input  logic [XLEN-1:0] res_pc,
  input  logic [XLEN-1:0] res_target,
  input  logic            res_predicted,
  output logic            taken,
  output logic            mispredict,
  output logic [XLEN-1:0] redirect_pc,
  output logic [31:0]     br_count,
  output logic [31:0]     mis_count
);

  localparam int IDXW = $clog2(ENTRIES);

  bht_cnt_t        r_bht [ENTRIES];
  logic            r_pred_taken;
  logic            r_pred_taken_valid;
  logic            r_mispredict;
  logic [XLEN-1:0] r_redirect_pc;
  logic [31:0]     r_br_count;
  logic [31:0]     r_mis_count;

  logic [IDXW-1:0] w_idx_pred;
  logic [IDXW-1:0] w_idx_res;
  logic            w_cond;
  logic            w_legal;
  logic            w_taken;
  logic            w_resolve;
  logic            w_mis;
  bht_cnt_t        w_cnt_res;

  // Word-aligned PCs: the two LSBs never select an entry, nor do PC bits
  // above the index field.
  assign w_idx_pred = pred_pc[IDXW+1:2];
  assign w_idx_res  = res_pc[IDXW+1:2];

  logic w_unused;
  assign w_unused = ^{pred_pc[XLEN-1:IDXW+2], pred_pc[1:0]};

  branch_cond #(.XLEN(XLEN)) u_cond (
    .funct3 (res_funct3),
    .rs1    (res_rs1),
    .rs2    (res_rs2),
    .cond   (w_cond),
    .legal  (w_legal)
  );

  assign w_resolve = res_valid & res_branch & w_legal;
  assign w_taken   = w_resolve & w_cond;
  assign w_mis     = w_resolve & (w_taken != res_predicted);
  assign w_cnt_res = r_bht[w_idx_res];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) r_bht[i] <= CNT_INIT;
      r_pred_taken       <= 1'b0;
      r_pred_taken_valid <= 1'b0;
      r_mispredict       <= 1'b0;
      r_redirect_pc      <= '0;
      r_br_count         <= '0;
      r_mis_count        <= '0;
    end else begin
      // Lookup reads the array before this edge's update lands, so a
      // same-index lookup sees the pre-update counter.
      if (pred_valid) r_pred_taken <= r_bht[w_idx_pred][1];
      r_pred_taken_valid <= pred_valid;
      r_mispredict       <= w_mis;

      if (w_resolve) begin
        r_br_count <= r_br_count + 32'd1;
        if (w_taken) begin
          if (w_cnt_res != CNT_ST) r_bht[w_idx_res] <= w_cnt_res + 2'd1;
        end else begin
          if (w_cnt_res != CNT_SNT) r_bht[w_idx_res] <= w_cnt_res - 2'd1;
        end
      end

      if (w_mis) begin
        r_mis_count   <= r_mis_count + 32'd1;
        r_redirect_pc <= w_taken ? res_target : (res_pc + XLEN'(4));
      end
    end
  end

  assign taken            = w_taken;
  assign pred_taken       = r_pred_taken;
  assign pred_taken_valid = r_pred_taken_valid;
  assign mispredict       = r_mispredict;
  assign redirect_pc      = r_redirect_pc;
  assign br_count         = r_br_count;
  assign mis_count        = r_mis_count;

endmodule

// File: doc/branch_unit_bht.md
# branch_unit_bht

Parametrised branch resolution unit with an integrated branch history table (BHT) of 2-bit saturating counters. It sits between fetch and execute. Fetch gets a registered taken/not-taken prediction per PC. Execute resolves conditional branches from raw operands and funct3, trains the BHT, and raises a registered mispredict/redirect to the pipeline. Two free-running performance counters track resolved branches and mispredicts.

## Interface
Parameters:
- XLEN, 32, operand/PC width
- ENTRIES, 64, BHT depth; power of two, ≥2
- CNT_INIT, 2'b01, counter value after reset (weakly not-taken)

Ports:
- clk  in  1  clock
- rst  in  1  reset; one clock, synchronous, active-high
- pred_valid  in  1  fetch lookup request
- pred_pc  in  XLEN  fetch PC
- pred_taken  out  1  registered prediction: counter MSB
- pred_taken_valid  out  1  pred_valid delayed one cycle
- res_valid  in  1  execute-stage instruction valid
- res_branch  in  1  instruction is a conditional branch
- res_funct3  in  3  branch condition
- res_rs1, res_rs2  in  XLEN  operands
- res_pc  in  XLEN  branch PC
- res_target  in  XLEN  computed branch target
- res_predicted  in  1  prediction carried down the pipe for this branch
- taken  out  1  combinational resolved outcome
- mispredict  out  1  registered, one-cycle pulse
- redirect_pc  out  XLEN  registered correct next PC, valid with mispredict
- br_count  out  32  resolved-branch counter
- mis_count  out  32  mispredict counter

## Operation
- Index = pc[$clog2(ENTRIES)+1:2]; low two PC bits ignored.
- Conditions:
  - 000 eq
  - 001 ne
  - 100 signed lt
  - 101 signed ge
  - 110 unsigned lt
  - 111 unsigned ge
  - 010/011 illegal: taken=0, no training, no counting, no mispredict.
- taken = res_valid & res_branch & cond. Otherwise 0; never latches.
- A resolve is a cycle with res_valid & res_branch & legal funct3.
- On a resolve:
  - Counter at index(res_pc) increments if taken, decrements if not. It saturates at 3 and 0.
  - br_count increments.
  - If taken != res_predicted: mispredict=1 next cycle and mis_count increments. redirect_pc = taken ? res_target : res_pc+4, with modulo 2^XLEN wrap.
- Perf counters wrap at 2^32.

## Timing
- Prediction latency: 1 cycle. pred_taken/pred_taken_valid are registered from pred_pc/pred_valid sampled at the edge.
- If pred_valid=0, pred_taken_valid=0 and pred_taken holds its last value.
- Lookup and update to the same index in the same cycle: lookup returns the pre-update counter (read-before-write).
- Mispredict latency: 1 cycle after the resolve edge. It is a pulse with no handshake; the pipeline must accept it.
- Back-to-back resolves are each handled independently, one per cycle.
- Reset values: all BHT entries = CNT_INIT. pred_taken, pred_taken_valid, mispredict = 0. redirect_pc = 0. br_count = mis_count = 0.
- Reset asserted mid-operation takes priority over a simultaneous resolve: no update, no mispredict next cycle.
- Inputs are ignored while rst=1.

## Structure
- Shared package branch_pkg:
  - funct3 localparams F3_BEQ, F3_BNE, F3_BLT, F3_BGE, F3_BLTU, F3_BGEU
  - typedef bht_cnt_t (2-bit)
  - constants CNT_SNT=0, CNT_WNT=1, CNT_WT=2, CNT_ST=3
- Sub-module branch_cond: combinational compare plus funct3 decode, producing cond and legal. It is the only combinational child.
- The BHT is a flop array with synchronous reset; no SRAM macro at this depth.

## Test plan
- Reset, then pred_valid with pred_pc=0x100 -> next cycle pred_taken_valid=1, pred_taken=0. Both perf counters are 0.
- BEQ, rs1=rs2=5, pc=0x100, res_predicted=0 -> taken=1. Next cycle mispredict=1, redirect_pc=target, mis_count=1. After three such resolves, lookup 0x100 -> pred_taken=1 (counter 3, saturated).
- BLT with rs1=0xFFFFFFFF, rs2=1 -> taken=1. BLTU with the same operands -> taken=0.
- Same-cycle lookup and taken resolve at pc=0x200 from CNT_INIT -> pred_taken=0, and the following lookup -> 1.
- funct3=010 with res_branch=1 -> taken=0, no mispredict, br_count unchanged. res_pc=0xFFFFFFFC not-taken mispredict -> redirect_pc=0x0.
- rst asserted in the same cycle as a mispredicting resolve -> mispredict stays 0, and all counters read CNT_INIT afterward.
